// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared widths, special instruction encodings and the fetch run-control
// state encoding used by the MIPS pipeline stages.
//   NB_PC          : PC / target-address width
//   NB_INSTRUCTION : instruction width
//   HALT_INSTR     : encoding that stops fetching
//   NOP_INSTR      : squash / bubble encoding
//   fetch_state_t  : IDLE=0, RUN=1, HALTED=2
package pipeline_pkg;

  localparam int NB_PC          = 32;
  localparam int NB_INSTRUCTION = 32;

  localparam logic [NB_INSTRUCTION-1:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [NB_INSTRUCTION-1:0] NOP_INSTR  = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE   = 2'd0,
    FETCH_RUN    = 2'd1,
    FETCH_HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_mem.sv
// instr_mem
// Instruction memory: 2^MEM_ADDR_W words of NB_INSTRUCTION bits.
// Synchronous write port (debug loader), asynchronous read port (fetch).
// A read of the address being written returns the old word until the edge.
// Ports:
//   i_clock    : write clock (rising edge)
//   i_wr_en    : write strobe
//   i_wr_addr  : word address to write
//   i_wr_data  : word to store
//   i_rd_addr  : word address to read
//   o_rd_data  : word at i_rd_addr (combinational)
module instr_mem
  import pipeline_pkg::*;
#(
  parameter int NB_INSTRUCTION = pipeline_pkg::NB_INSTRUCTION,
  parameter int MEM_ADDR_W     = 8
) (
  input  logic                      i_clock,
  input  logic                      i_wr_en,
  input  logic [MEM_ADDR_W-1:0]     i_wr_addr,
  input  logic [NB_INSTRUCTION-1:0] i_wr_data,
  input  logic [MEM_ADDR_W-1:0]     i_rd_addr,
  output logic [NB_INSTRUCTION-1:0] o_rd_data
);

  localparam int DEPTH = 1 << MEM_ADDR_W;

  // No reset on the array: contents survive a pipeline reset so a loaded
  // program can be rerun.
  logic [NB_INSTRUCTION-1:0] mem_array [DEPTH];

  always_ff @(posedge i_clock) begin
    if (i_wr_en) begin
      mem_array[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem_array[i_rd_addr];

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit
// Instruction-fetch stage: PC register, PC+4 adder, next-PC selection
// (jump_reg > jump > branch > PC+4), local instruction memory and an
// IDLE/RUN/HALTED run-control FSM driven by the debug unit.
// Ports:
//   i_clock           : clock, rising edge
//   i_reset_n         : asynchronous active-low reset
//   i_start           : leave IDLE and begin fetching
//   i_enable_pc       : 1 = PC may advance, 0 = stall
//   i_branch_taken    : ID-stage branch taken, target i_branch_addr
//   i_jump            : J/JAL, target i_jump_addr
//   i_jump_reg        : JR/JALR, target i_jump_reg_addr
//   i_mem_wr_*        : debug write port into instruction memory
//   o_adder_result    : PC+4 (to IF/ID)
//   o_new_instruction : fetched word or NOP bubble (to IF/ID)
//   o_pc              : current PC
//   o_halted          : FSM is in HALTED
module if_fetch_unit
  import pipeline_pkg::*;
#(
  parameter int                         NB_PC          = pipeline_pkg::NB_PC,
  parameter int                         NB_INSTRUCTION = pipeline_pkg::NB_INSTRUCTION,
  parameter int                         MEM_ADDR_W     = 8,
  parameter logic [NB_INSTRUCTION-1:0]  HALT_INSTR     = pipeline_pkg::HALT_INSTR,
  parameter logic [NB_INSTRUCTION-1:0]  NOP_INSTR      = pipeline_pkg::NOP_INSTR
) (
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  input  logic                      i_start,
  input  logic                      i_enable_pc,
  input  logic                      i_branch_taken,
  input  logic [NB_PC-1:0]          i_branch_addr,
  input  logic                      i_jump,
  input  logic [NB_PC-1:0]          i_jump_addr,
  input  logic                      i_jump_reg,
  input  logic [NB_PC-1:0]          i_jump_reg_addr,
  input  logic                      i_mem_wr_en,
  input  logic [MEM_ADDR_W-1:0]     i_mem_wr_addr,
  input  logic [NB_INSTRUCTION-1:0] i_mem_wr_data,
  output logic [NB_PC-1:0]          o_adder_result,
  output logic [NB_INSTRUCTION-1:0] o_new_instruction,
  output logic [NB_PC-1:0]          o_pc,
  output logic                      o_halted
);

  fetch_state_t              state_reg;
  fetch_state_t              state_next;
  logic [NB_PC-1:0]          pc_reg;
  logic [NB_PC-1:0]          pc_next;
  logic [NB_PC-1:0]          pc_plus4;
  logic [NB_PC-1:0]          redirect_target;
  logic                      redirect;
  logic [NB_INSTRUCTION-1:0] mem_word;

  // Memory is word addressed; PC bits above the array are ignored so
  // addresses alias.
  instr_mem #(
    .NB_INSTRUCTION (NB_INSTRUCTION),
    .MEM_ADDR_W     (MEM_ADDR_W)
  ) u_instr_mem (
    .i_clock   (i_clock),
    .i_wr_en   (i_mem_wr_en),
    .i_wr_addr (i_mem_wr_addr),
    .i_wr_data (i_mem_wr_data),
    .i_rd_addr (pc_reg[MEM_ADDR_W+1:2]),
    .o_rd_data (mem_word)
  );

  // Wraps modulo 2^NB_PC by construction.
  assign pc_plus4 = pc_reg + NB_PC'(4);
  assign redirect = i_jump_reg | i_jump | i_branch_taken;

  always_comb begin
    if (i_jump_reg) begin
      redirect_target = i_jump_reg_addr;
    end else if (i_jump) begin
      redirect_target = i_jump_addr;
    end else begin
      redirect_target = i_branch_addr;
    end
  end

  // State and PC registers.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg <= FETCH_IDLE;
      pc_reg    <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  // Next-state / next-PC logic. Redirects only act in RUN with the PC
  // enabled; a stalled ID stage re-presents them later.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    unique case (state_reg)
      FETCH_IDLE: begin
        if (i_start) begin
          state_next = FETCH_RUN;
        end
      end
      FETCH_RUN: begin
        if (i_enable_pc) begin
          if (redirect) begin
            pc_next = redirect_target;
          end else if (mem_word == HALT_INSTR) begin
            // PC stays on the HALT address.
            state_next = FETCH_HALTED;
          end else begin
            pc_next = pc_plus4;
          end
        end
      end
      FETCH_HALTED: begin
        state_next = FETCH_HALTED;
      end
      default: begin
        state_next = FETCH_IDLE;
      end
    endcase
  end

  // Output logic. A stalled RUN cycle passes the word through untouched
  // because IF/ID is frozen too; a redirect squashes the wrong-path fetch.
  // The HALT word itself is forwarded so it travels down the pipeline.
  always_comb begin
    o_new_instruction = NOP_INSTR;
    o_halted          = 1'b0;
    unique case (state_reg)
      FETCH_IDLE: begin
        o_new_instruction = NOP_INSTR;
      end
      FETCH_RUN: begin
        if (i_enable_pc && redirect) begin
          o_new_instruction = NOP_INSTR;
        end else begin
          o_new_instruction = mem_word;
        end
      end
      FETCH_HALTED: begin
        o_new_instruction = NOP_INSTR;
        o_halted          = 1'b1;
      end
      default: begin
        o_new_instruction = NOP_INSTR;
      end
    endcase
  end

  assign o_pc           = pc_reg;
  assign o_adder_result = pc_plus4;

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. It is the producer side of the IF/ID pipeline register. It holds the PC, computes PC+4 and selects the next PC among sequential, branch, jump and jump-register targets. It reads a local instruction memory and drives the fetched instruction plus PC+4 into IF/ID. A small run-control FSM (IDLE/RUN/HALTED) gates fetching for the debug unit.

Parameters:
NB_PC, 32, PC and target-address width
NB_INSTRUCTION, 32, instruction width
MEM_ADDR_W, 8, word-address width of instruction memory (256 words)
HALT_INSTR, 32'hFFFF_FFFF, encoding that stops fetching
NOP_INSTR, 32'h0000_0000, squash/bubble encoding

Ports:
i_clock  in  1  clock; PC, FSM and memory writes update on rising edge
i_reset_n  in  1  asynchronous, active-low reset
i_start  in  1  debug unit: begin fetching (IDLE only)
i_enable_pc  in  1  stall unit: 1 = PC may advance, 0 = hold
i_branch_taken  in  1  ID-stage branch resolved taken
i_branch_addr  in  NB_PC  branch target
i_jump  in  1  J/JAL
i_jump_addr  in  NB_PC  jump target
i_jump_reg  in  1  JR/JALR
i_jump_reg_addr  in  NB_PC  register target
i_mem_wr_en  in  1  debug write strobe
i_mem_wr_addr  in  MEM_ADDR_W  word address
i_mem_wr_data  in  NB_INSTRUCTION  word to store
o_adder_result  out  NB_PC  PC+4, to IF/ID
o_new_instruction  out  NB_INSTRUCTION  fetched or squashed instruction, to IF/ID
o_pc  out  NB_PC  current PC (debug)
o_halted  out  1  FSM in HALTED

Behaviour:
- Reset (async, i_reset_n=0): PC=0, state=IDLE, o_halted=0. Memory contents are not reset. While in reset: o_pc=0, o_adder_result=4, o_new_instruction=NOP_INSTR.
- Memory: asynchronous read at word index PC[MEM_ADDR_W+1:2]. Upper PC bits are ignored, so addresses alias/wrap. Write occurs on the rising edge when i_mem_wr_en=1, in any state. A same-cycle read of the written address returns the old word until the edge.
- o_adder_result = PC+4, modulo 2^NB_PC (32'hFFFF_FFFC -> 0). It is combinational from PC, so IF/ID (falling-edge capture) sees stable values.
- Redirect: redirect = i_jump_reg | i_jump | i_branch_taken. Next-PC priority is jump_reg > jump > branch > PC+4.
- FSM:
  - IDLE: hold PC; output NOP. i_start=1 -> RUN at next edge.
  - RUN, i_enable_pc=0: hold PC; output memory word unmodified (IF/ID is also stalled).
  - RUN, i_enable_pc=1, redirect=1: PC <= selected target; o_new_instruction=NOP this cycle (squash wrong-path fetch); no halt check.
  - RUN, i_enable_pc=1, redirect=0, word==HALT_INSTR: HALT is output this cycle so it propagates down the pipeline; PC held; state -> HALTED.
  - RUN, i_enable_pc=1, otherwise: PC <= PC+4; output memory word.
  - HALTED: PC frozen at the HALT address; output NOP; o_halted=1. Inputs are ignored except memory writes. Exit only by reset.
- i_start outside IDLE: no effect.
- Redirects while not in RUN, or in RUN with i_enable_pc=0: ignored (stall wins; the ID stage re-presents the redirect).
- Reset mid-run: next state is IDLE with PC=0, regardless of any pending redirect.

Decomposition:
- Shared package (pipeline_pkg): NB_PC, NB_INSTRUCTION, HALT_INSTR, NOP_INSTR, and the fetch FSM state encoding (IDLE=2'd0, RUN=2'd1, HALTED=2'd2).
- One sub-module, instr_mem: a 2^MEM_ADDR_W x NB_INSTRUCTION array with a synchronous write port and an asynchronous read port. The PC register, next-PC mux and FSM stay in if_fetch_unit.

Test Plan:
- Load words 0x20010005, 0x20020007, 0xFFFFFFFF at addresses 0..2; reset; i_start. Required: o_pc steps 0, 4, 8, then holds at 8. o_new_instruction shows the three words in order. o_halted=1 the cycle after the HALT fetch, then NOP thereafter.
- In RUN at PC=8, drop i_enable_pc for 3 cycles. Required: o_pc=8 and o_adder_result=12 for all 3 cycles; fetch resumes at 12 when re-enabled.
- At PC=0x10, assert i_branch_taken with target 0x40. Required: o_new_instruction=0 that cycle; o_pc=0x40 next cycle.
- Assert all three redirects with jump_reg=0x80, jump=0x100, branch=0x40. Required: next o_pc=0x80.
- HALT at address 4 with i_jump (target 0x20) asserted in the same cycle. Required: NOP output, no halt, o_pc=0x20.
- Deassert i_reset_n asynchronously mid-run at PC=0x24. Required: o_pc=0 immediately with no clock edge needed. FSM returns to IDLE; memory contents are intact.
